uart_core: RTL and testbench
============================

# uart_core

Parametrised full-duplex UART engine replacing the fixed 8N1 transmitter/receiver/baud-generator trio. It has a runtime baud divisor with 16x receive oversampling, selectable parity and stop bits, valid/ready handshakes on both data paths, and per-frame error reporting. It sits between the system bus logic and the `txd`/`rxd` pins, and has an internal loopback for self-test.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, legal range 5..9.
- `DIV_W`, default 16: width of the baud divisor.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `baud_div`  in  DIV_W  oversample tick period minus one; 16x tick = clk/(baud_div+1).
- `parity_mode`  in  2  0 none, 1 even, 2 odd, 3 none.
- `two_stop`  in  1  1 = transmit two stop bits; RX always checks only the first.
- `loopback`  in  1  1 = RX input is internal `txd`; external `rxd` is ignored.
- `tx_data`  in  DATA_BITS  byte to send.
- `tx_valid`  in  1  `tx_data` is offered.
- `tx_ready`  out  1  transmitter idle and can accept a byte.
- `txd`  out  1  serial output, idle high.
- `rxd`  in  1  serial input, asynchronous to `clk`.
- `rx_data`  out  DATA_BITS  received payload.
- `rx_valid`  out  1  `rx_data` and error flags are held until accepted.
- `rx_ready`  in  1  consumer accepts `rx_data`.
- `rx_parity_err`  out  1  parity mismatch on the held frame.
- `rx_frame_err`  out  1  first stop bit sampled low on the held frame.
- `rx_overrun`  out  1  one-cycle pulse: a frame completed while `rx_valid` was high and was dropped.

## Operation
- Reset values:
  - `txd`=1, `tx_ready`=1, `rx_valid`=0.
  - `rx_data`=0, all error flags 0, `rx_overrun`=0.
  - Both FSMs in IDLE, all counters 0.
- Configuration inputs are sampled continuously. They must be held stable while `tx_ready`=0 or the RX FSM is not in IDLE; the result is undefined otherwise.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: accept on `tx_valid & tx_ready`. Latch `tx_data`, drop `tx_ready`, restart the TX prescaler, go to START.
  - Each bit lasts 16 ticks, i.e. 16*(baud_div+1) clk cycles.
  - DATA sends LSB first, DATA_BITS bits.
  - PARITY is skipped when parity_mode is 0 or 3. Even parity: bit = XOR of the data bits. Odd parity: its inverse.
  - STOP lasts 1 or 2 bit times. `tx_ready` rises on the cycle after the final stop bit ends.
- RX path:
  - `rxd` passes through a 2-flop synchroniser; the loopback mux sits after it.
  - The RX prescaler is free-running.
  - A high-to-low transition in IDLE starts START and zeroes the tick counter.
  - At tick 8 of START, if the line is high (false start), return to IDLE with no output.
  - Each bit value is the majority of the samples at ticks 7, 8 and 9.
  - States: IDLE, START, DATA, PARITY, STOP.
  - At tick 9 of STOP the RX returns to IDLE and the frame completes. It can detect a new start bit from the next tick.
- Frame completion with `rx_valid`=0: load `rx_data` and both error flags, set `rx_valid`.
- Frame completion with `rx_valid`=1 and no `rx_ready` that cycle: discard the new frame, pulse `rx_overrun`, keep the held data.
- Completion and `rx_ready` in the same cycle: the new frame is loaded and `rx_valid` stays 1.
- Parity and frame errors do not suppress `rx_valid`.
- When DATA_BITS < 9, the unused upper payload register bits do not exist.

## Timing
- TX latency: `txd` falls on the clk edge after the accepting edge.
- TX frame length = (1 + DATA_BITS + P + S) * 16 * (baud_div+1) cycles. P = 1 if parity is enabled, else 0; S = 1 or 2 stop bits.
- Back-to-back TX: if `tx_valid` is already high when `tx_ready` rises, the next start bit follows with zero idle cycles beyond the one accept cycle.
- RX latency: `rx_valid` rises 1 clk after the STOP tick-9 sample. Add 2 clk for the synchroniser when measuring from `rxd`.
- `baud_div`=0 is legal (tick every clk). The prescaler wraps at `baud_div`.
- Asynchronous reset mid-frame aborts both FSMs immediately. `txd`=1 while in reset. The partial RX frame is lost and no `rx_valid` is produced.

## Structure
- `uart_pkg` holds:
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the TX and RX state enums;
  - OVERSAMPLE=16 and the sample-tick constants 7/8/9.
- One sub-module, `uart_baud_tick`: DIV_W down-counter with a synchronous restart input, emitting a one-cycle tick. It is instantiated twice, once for TX (restart on accept) and once for RX (free-running).
- The TX and RX FSMs stay in `uart_core`.

## Test plan
- Loopback, baud_div=0, 8N1, send 0xA5:
  - `txd` low for cycles 1-16, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high;
  - `rx_valid` with `rx_data`=0xA5 and no errors;
  - `tx_ready` returns after 160 cycles.
- Even parity, two_stop=1, baud_div=3, send 0x07 (three ones): parity bit = 1; stop period is 128 cycles; RX returns 0x07 with `rx_parity_err`=0. Repeat with odd parity: parity bit = 0.
- External `rxd` driven with 0x3C but stop bit low -> `rx_valid`=1, `rx_data`=0x3C, `rx_frame_err`=1. Flip the parity bit -> `rx_parity_err`=1.
- `rxd` low pulse of 4 cycles at baud_div=0 -> no `rx_valid`, RX back in IDLE; a following valid 0x55 frame is received correctly.
- Two frames 0x11 then 0x22 with `rx_ready`=0 -> `rx_data` stays 0x11 and `rx_overrun` pulses once. Assert `rx_ready` in the same cycle as the third frame's completion -> 0x33 is loaded with no overrun.
- Assert `rst`=0 mid-DATA during TX -> `txd`=1 and `tx_ready`=1 immediately, no `rx_valid`; the next 0xF0 transfer is correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the UART engine.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;

   localparam int         OVERSAMPLE   = 16;
   localparam logic [3:0] LAST_TICK    = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] SAMPLE_EARLY = 4'd7;
   localparam logic [3:0] SAMPLE_MID   = 4'd8;
   localparam logic [3:0] SAMPLE_LATE  = 4'd9;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   // Modes 0 and 3 both mean "no parity bit on the wire".
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_core_if.sv
// Bus-side data paths of the UART engine.
//
// Handshake rule for both paths: a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender keeps data stable and valid
// asserted until that edge; valid never depends combinationally on ready.
// On RX, rx_data and both error flags belong to the held frame and stay put
// while rx_valid is 1. rx_overrun is a standalone one-cycle pulse.
interface uart_core_if #(parameter int DATA_BITS = 8);

   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   logic                 rx_overrun;

   modport master (
      output tx_data, tx_valid, rx_ready,
      input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
   );

   modport slave (
      input  tx_data, tx_valid, rx_ready,
      output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
   );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick prescaler: one-cycle tick every div+1 clk cycles.
// restart reloads the counter so the first tick lands div+1 cycles later.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic             restart,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;

   // Down-counter that reloads from div on wrap or on restart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (restart || cnt == '0) begin
         cnt <= div;
      end else begin
         cnt <= cnt - DIV_W'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART engine: TX/RX FSMs, 16x oversampled receive,
// optional parity, one or two stop bits, internal loopback.
module uart_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [1:0]       parity_mode,
   input  logic             two_stop,
   input  logic             loopback,
   output logic             txd,
   input  logic             rxd,
   uart_core_if.slave       bus,
   output tx_state_e        tx_state_dbg,
   output rx_state_e        rx_state_dbg
);

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   // ---------------- TX ----------------
   tx_state_e            tx_state;
   logic                 tx_ready_q;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par;
   logic [3:0]           tx_tick_cnt;
   logic [3:0]           tx_bit_cnt;
   logic                 tx_tick;
   logic                 tx_accept;
   logic                 tx_bit_end;

   assign tx_accept  = bus.tx_valid && tx_ready_q;
   assign tx_bit_end = tx_tick && (tx_tick_cnt == LAST_TICK);

   uart_baud_tick #(.DIV_W(DIV_W)) u_tx_tick (
      .clk     (clk),
      .rst     (rst),
      .div     (baud_div),
      .restart (tx_accept),
      .tick    (tx_tick)
   );

   // TX FSM; txd is registered from the current state so the line lags by one clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state    <= TX_IDLE;
         tx_ready_q  <= 1'b1;
         txd         <= 1'b1;
         tx_shift    <= '0;
         tx_par      <= 1'b0;
         tx_tick_cnt <= '0;
         tx_bit_cnt  <= '0;
      end else begin
         if (tx_state != TX_IDLE && tx_tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
         end
         case (tx_state)
            TX_IDLE: begin
               if (tx_accept) begin
                  tx_shift    <= bus.tx_data;
                  tx_par      <= ^bus.tx_data;
                  tx_ready_q  <= 1'b0;
                  tx_tick_cnt <= '0;
                  tx_bit_cnt  <= '0;
                  tx_state    <= TX_START;
               end
            end
            TX_START: begin
               if (tx_bit_end) tx_state <= TX_DATA;
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_shift <= tx_shift >> 1;
                  if (tx_bit_cnt == LAST_BIT) begin
                     tx_bit_cnt <= '0;
                     tx_state   <= parity_enabled(parity_mode) ? TX_PARITY : TX_STOP;
                  end else begin
                     tx_bit_cnt <= tx_bit_cnt + 4'd1;
                  end
               end
            end
            TX_PARITY: begin
               if (tx_bit_end) tx_state <= TX_STOP;
            end
            TX_STOP: begin
               if (tx_bit_end) begin
                  if (two_stop && tx_bit_cnt == 4'd0) begin
                     tx_bit_cnt <= 4'd1;
                  end else begin
                     tx_state   <= TX_IDLE;
                     tx_ready_q <= 1'b1;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
         case (tx_state)
            TX_START:  txd <= 1'b0;
            TX_DATA:   txd <= tx_shift[0];
            TX_PARITY: txd <= tx_par ^ (parity_mode == PAR_ODD);
            default:   txd <= 1'b1;
         endcase
      end
   end

   assign bus.tx_ready = tx_ready_q;
   assign tx_state_dbg = tx_state;

   // ---------------- RX ----------------
   rx_state_e            rx_state;
   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_line;
   logic                 rx_last;
   logic                 rx_tick;
   logic [3:0]           rx_tick_cnt;
   logic [3:0]           rx_idx;
   logic [3:0]           rx_bit_cnt;
   logic                 rx_s7;
   logic                 rx_s8;
   logic                 rx_bit;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par_err_q;
   logic                 rx_frame_err_q;
   logic                 rx_done;
   logic                 rx_valid_q;
   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_parity_err_q;
   logic                 rx_frame_err_o;
   logic                 rx_overrun_q;

   uart_baud_tick #(.DIV_W(DIV_W)) u_rx_tick (
      .clk     (clk),
      .rst     (rst),
      .div     (baud_div),
      .restart (1'b0),
      .tick    (rx_tick)
   );

   // Two-flop synchroniser for the asynchronous rxd pin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
      end
   end

   assign rx_line = loopback ? txd : rx_sync;
   // Index of the current tick within the bit; wraps 15 -> 0 into the next bit.
   assign rx_idx  = rx_tick_cnt + 4'd1;
   assign rx_bit  = (rx_s7 & rx_s8) | (rx_s7 & rx_line) | (rx_s8 & rx_line);

   // RX FSM: start detect, mid-bit majority sampling, frame completion strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state       <= RX_IDLE;
         rx_last        <= 1'b1;
         rx_tick_cnt    <= '0;
         rx_bit_cnt     <= '0;
         rx_s7          <= 1'b1;
         rx_s8          <= 1'b1;
         rx_shift       <= '0;
         rx_par_err_q   <= 1'b0;
         rx_frame_err_q <= 1'b0;
         rx_done        <= 1'b0;
      end else begin
         rx_done <= 1'b0;
         if (rx_tick) begin
            rx_last <= rx_line;
            if (rx_state != RX_IDLE) begin
               rx_tick_cnt <= rx_idx;
               if (rx_idx == SAMPLE_EARLY) rx_s7 <= rx_line;
               if (rx_idx == SAMPLE_MID)   rx_s8 <= rx_line;
            end
            case (rx_state)
               RX_IDLE: begin
                  if (rx_last && !rx_line) begin
                     rx_tick_cnt  <= '0;
                     rx_bit_cnt   <= '0;
                     rx_par_err_q <= 1'b0;
                     rx_state     <= RX_START;
                  end
               end
               RX_START: begin
                  if (rx_idx == SAMPLE_MID && rx_line) begin
                     rx_state <= RX_IDLE;
                  end else if (rx_idx == LAST_TICK) begin
                     rx_state <= RX_DATA;
                  end
               end
               RX_DATA: begin
                  if (rx_idx == SAMPLE_LATE) begin
                     rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
                  end
                  if (rx_idx == LAST_TICK) begin
                     if (rx_bit_cnt == LAST_BIT) begin
                        rx_bit_cnt <= '0;
                        rx_state   <= parity_enabled(parity_mode) ? RX_PARITY : RX_STOP;
                     end else begin
                        rx_bit_cnt <= rx_bit_cnt + 4'd1;
                     end
                  end
               end
               RX_PARITY: begin
                  if (rx_idx == SAMPLE_LATE) begin
                     rx_par_err_q <= rx_bit ^ (^rx_shift) ^ (parity_mode == PAR_ODD);
                  end
                  if (rx_idx == LAST_TICK) rx_state <= RX_STOP;
               end
               RX_STOP: begin
                  if (rx_idx == SAMPLE_LATE) begin
                     rx_frame_err_q <= ~rx_bit;
                     rx_done        <= 1'b1;
                     rx_state       <= RX_IDLE;
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   // Output holding register: load, hold-and-drop (overrun), or release on accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_valid_q      <= 1'b0;
         rx_data_q       <= '0;
         rx_parity_err_q <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_overrun_q    <= 1'b0;
      end else begin
         rx_overrun_q <= 1'b0;
         if (rx_done) begin
            if (!rx_valid_q || bus.rx_ready) begin
               rx_valid_q      <= 1'b1;
               rx_data_q       <= rx_shift;
               rx_parity_err_q <= rx_par_err_q;
               rx_frame_err_o  <= rx_frame_err_q;
            end else begin
               rx_overrun_q <= 1'b1;
            end
         end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign bus.rx_valid      = rx_valid_q;
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_parity_err = rx_parity_err_q;
   assign bus.rx_frame_err  = rx_frame_err_o;
   assign bus.rx_overrun    = rx_overrun_q;
   assign rx_state_dbg      = rx_state;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback TX waveforms, external RX frames,
// false start, overrun, and reset mid-frame.
module tb_uart_core;
   import uart_pkg::*;

   localparam int DB = 8;

   logic        clk;
   logic        rst;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic        loopback;
   logic        txd;
   logic        rxd;
   tx_state_e   tx_state_dbg;
   rx_state_e   rx_state_dbg;

   uart_core_if #(.DATA_BITS(DB)) bus ();

   uart_core #(.DATA_BITS(DB), .DIV_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .baud_div     (baud_div),
      .parity_mode  (parity_mode),
      .two_stop     (two_stop),
      .loopback     (loopback),
      .txd          (txd),
      .rxd          (rxd),
      .bus          (bus.slave),
      .tx_state_dbg (tx_state_dbg),
      .rx_state_dbg (rx_state_dbg)
   );

   // ---- clock / reset ----
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---- scoreboard ----
   int n_checks = 0;
   int n_errors = 0;
   int ovr_cnt  = 0;
   logic [DB-1:0] exp_q[$];

   always @(negedge clk) begin
      if (bus.rx_overrun === 1'b1) ovr_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---- drivers ----
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one byte through TX and compares txd every clk against a bit list
   // built from the frame format. Also returns the txd level mid parity bit.
   task automatic tx_frame(input string tag, input logic [7:0] data, input logic [1:0] pm,
                           input logic ts, output logic par_seen);
      logic bits [0:11];
      int   nb, bc, total, bad, par_idx;
      logic rdy_early, rdy_end;
      nb = 0; par_idx = -1; bad = 0; par_seen = 1'bx;
      rdy_early = 1'bx; rdy_end = 1'bx;
      bc = 16 * (int'(baud_div) + 1);
      bits[nb] = 1'b0; nb++;
      for (int i = 0; i < 8; i++) begin bits[nb] = data[i]; nb++; end
      if (pm == PAR_EVEN || pm == PAR_ODD) begin
         bits[nb] = (^data) ^ (pm == PAR_ODD); par_idx = nb; nb++;
      end
      bits[nb] = 1'b1; nb++;
      if (ts) begin bits[nb] = 1'b1; nb++; end
      total = nb * bc;
      check_eq({tag, "_rdy_pre"}, {31'd0, bus.tx_ready}, 32'd1);
      bus.tx_data  = data;
      bus.tx_valid = 1'b1;
      cycles(1);
      bus.tx_valid = 1'b0;
      for (int k = 1; k <= total; k++) begin
         cycles(1);
         if (txd !== bits[(k - 1) / bc]) bad++;
         if (par_idx >= 0 && k == par_idx * bc + bc / 2) par_seen = txd;
         if (k == total - 1) rdy_early = bus.tx_ready;
         if (k == total) rdy_end = bus.tx_ready;
      end
      check_eq({tag, "_txd_wave"}, bad, 0);
      check_eq({tag, "_rdy_early"}, {31'd0, rdy_early}, 32'd0);
      check_eq({tag, "_rdy_end"}, {31'd0, rdy_end}, 32'd1);
   endtask

   task automatic drive_bit(input logic v, input int n);
      rxd = v;
      cycles(n);
   endtask

   // Drives one frame on the external rxd pin at the current baud_div.
   task automatic rx_frame(input logic [7:0] data, input logic [1:0] pm,
                           input logic flip_par, input logic stop_v);
      int bc;
      bc = 16 * (int'(baud_div) + 1);
      drive_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_bit(data[i], bc);
      if (pm == PAR_EVEN || pm == PAR_ODD) drive_bit((^data) ^ (pm == PAR_ODD) ^ flip_par, bc);
      drive_bit(stop_v, bc);
      drive_bit(1'b1, bc);
   endtask

   // Waits for a held frame, compares it with the next expected byte, accepts it.
   task automatic rx_collect(input string tag, input logic perr, input logic ferr);
      logic [DB-1:0] exp;
      for (int i = 0; i < 2000 && !bus.rx_valid; i++) cycles(1);
      check_eq({tag, "_valid"}, {31'd0, bus.rx_valid}, 32'd1);
      if (exp_q.size() == 0) begin
         n_checks++; n_errors++;
         $display("FAIL %s_queue got=empty exp=entry", tag);
      end else begin
         exp = exp_q.pop_front();
         check_eq({tag, "_data"}, {24'd0, bus.rx_data}, {24'd0, exp});
      end
      check_eq({tag, "_perr"}, {31'd0, bus.rx_parity_err}, {31'd0, perr});
      check_eq({tag, "_ferr"}, {31'd0, bus.rx_frame_err}, {31'd0, ferr});
      bus.rx_ready = 1'b1;
      cycles(1);
      bus.rx_ready = 1'b0;
      check_eq({tag, "_released"}, {31'd0, bus.rx_valid}, 32'd0);
   endtask

   // ---- stimulus ----
   initial begin
      logic par_seen;
      int   ovr_base;
      rst = 1'b0; baud_div = '0; parity_mode = PAR_NONE; two_stop = 1'b0;
      loopback = 1'b0; rxd = 1'b1;
      bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
      cycles(3);

      // reset values
      check_eq("rst_txd",      {31'd0, txd}, 32'd1);
      check_eq("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
      check_eq("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
      check_eq("rst_rx_data",  {24'd0, bus.rx_data}, 32'd0);
      check_eq("rst_perr",     {31'd0, bus.rx_parity_err}, 32'd0);
      check_eq("rst_ferr",     {31'd0, bus.rx_frame_err}, 32'd0);
      check_eq("rst_overrun",  {31'd0, bus.rx_overrun}, 32'd0);
      check_eq("rst_tx_state", {29'd0, tx_state_dbg}, {29'd0, TX_IDLE});
      check_eq("rst_rx_state", {29'd0, rx_state_dbg}, {29'd0, RX_IDLE});
      rst = 1'b1;
      cycles(2);

      // loopback 8N1, baud_div=0, 0xA5
      loopback = 1'b1;
      exp_q.push_back(8'hA5);
      tx_frame("a5", 8'hA5, PAR_NONE, 1'b0, par_seen);
      rx_collect("a5", 1'b0, 1'b0);

      // even parity, two stop bits, baud_div=3, 0x07 -> parity bit 1
      baud_div = 16'd3; parity_mode = PAR_EVEN; two_stop = 1'b1;
      exp_q.push_back(8'h07);
      tx_frame("even", 8'h07, PAR_EVEN, 1'b1, par_seen);
      check_eq("even_par_bit", {31'd0, par_seen}, 32'd1);
      rx_collect("even", 1'b0, 1'b0);

      // odd parity -> parity bit 0
      parity_mode = PAR_ODD;
      exp_q.push_back(8'h07);
      tx_frame("odd", 8'h07, PAR_ODD, 1'b1, par_seen);
      check_eq("odd_par_bit", {31'd0, par_seen}, 32'd0);
      rx_collect("odd", 1'b0, 1'b0);

      // external rxd: stop bit low -> frame error
      loopback = 1'b0; baud_div = '0; parity_mode = PAR_NONE; two_stop = 1'b0;
      cycles(4);
      exp_q.push_back(8'h3C);
      rx_frame(8'h3C, PAR_NONE, 1'b0, 1'b0);
      rx_collect("ferr", 1'b0, 1'b1);

      // external rxd: flipped even parity bit -> parity error
      parity_mode = PAR_EVEN;
      exp_q.push_back(8'h3C);
      rx_frame(8'h3C, PAR_EVEN, 1'b1, 1'b1);
      rx_collect("perr", 1'b1, 1'b0);
      parity_mode = PAR_NONE;

      // false start: 4-cycle low glitch
      rxd = 1'b0; cycles(4);
      rxd = 1'b1; cycles(40);
      check_eq("glitch_no_valid", {31'd0, bus.rx_valid}, 32'd0);
      check_eq("glitch_rx_idle",  {29'd0, rx_state_dbg}, {29'd0, RX_IDLE});
      exp_q.push_back(8'h55);
      rx_frame(8'h55, PAR_NONE, 1'b0, 1'b1);
      rx_collect("after_glitch", 1'b0, 1'b0);

      // overrun: 0x11 then 0x22 with rx_ready low
      ovr_base = ovr_cnt;
      rx_frame(8'h11, PAR_NONE, 1'b0, 1'b1);
      rx_frame(8'h22, PAR_NONE, 1'b0, 1'b1);
      check_eq("ovr_held_valid", {31'd0, bus.rx_valid}, 32'd1);
      check_eq("ovr_held_data",  {24'd0, bus.rx_data}, 32'h11);
      check_eq("ovr_pulses",     ovr_cnt - ovr_base, 1);

      // third frame: rx_ready in the completion cycle -> 0x33 loaded, no overrun
      exp_q.push_back(8'h33);
      fork
         rx_frame(8'h33, PAR_NONE, 1'b0, 1'b1);
         begin
            for (int i = 0; i < 400 && rx_state_dbg != RX_STOP; i++) cycles(1);
            check_eq("ovr3_reach_stop", {29'd0, rx_state_dbg}, {29'd0, RX_STOP});
            for (int i = 0; i < 400 && rx_state_dbg == RX_STOP; i++) cycles(1);
            bus.rx_ready = 1'b1;
            cycles(1);
            bus.rx_ready = 1'b0;
            check_eq("ovr3_valid",   {31'd0, bus.rx_valid}, 32'd1);
            check_eq("ovr3_no_ovr",  {31'd0, bus.rx_overrun}, 32'd0);
            check_eq("ovr3_loaded",  {24'd0, bus.rx_data}, 32'h33);
         end
      join
      check_eq("ovr3_pulses", ovr_cnt - ovr_base, 1);
      rx_collect("ovr3", 1'b0, 1'b0);

      // asynchronous reset in the middle of a TX data bit
      loopback = 1'b1;
      bus.tx_data = 8'h81; bus.tx_valid = 1'b1;
      cycles(1);
      bus.tx_valid = 1'b0;
      cycles(50);
      check_eq("mid_tx_state", {29'd0, tx_state_dbg}, {29'd0, TX_DATA});
      rst = 1'b0;
      #1;
      check_eq("mid_rst_txd",      {31'd0, txd}, 32'd1);
      check_eq("mid_rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
      check_eq("mid_rst_rx_state", {29'd0, rx_state_dbg}, {29'd0, RX_IDLE});
      cycles(3);
      rst = 1'b1;
      cycles(200);
      check_eq("mid_rst_no_valid", {31'd0, bus.rx_valid}, 32'd0);
      exp_q.push_back(8'hF0);
      tx_frame("f0", 8'hF0, PAR_NONE, 1'b0, par_seen);
      rx_collect("f0", 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
